// File: rtl/mda_char_fetch.sv
// Purpose : MDA text fetch stage. Per scanline it walks COLS character cells, reads
//           {attr,code} from video RAM, looks up the font row, and presents one 9-dot
//           cell at a time to the pixel serializer.
// Latency : line_start at edge T -> LEAD (prefetch) cell at T+1, column k from T+10+9k.
// Backpr. : none; the serializer consumes one dot per pixclk, VRAM/ROM answer in 1 cycle.
// Ports   : pixclk/rst (sync, active-high); line_start/line_base/scanline begin a line;
//           vram_rd/vram_addr/vram_data = VRAM read port; font_addr/font_data = char ROM;
//           char_line/char_code/char_attr/char_pixel/cell_valid = current cell to serializer.
// Option  : `define MDA_CURSOR_EN adds cursor_addr/cursor_start/cursor_end/cursor_on and
//           forces the font row to 8'hFF on the cursor cell within the cursor row band.
module mda_char_fetch #(
  parameter int COLS   = 80,
  parameter int ADDR_W = 11
) (
  input  logic              pixclk,
  input  logic              rst,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_base,
  input  logic [3:0]        scanline,
  output logic              vram_rd,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [15:0]       vram_data,
  output logic [11:0]       font_addr,
  input  logic [7:0]        font_data,
`ifdef MDA_CURSOR_EN
  input  logic [ADDR_W-1:0] cursor_addr,
  input  logic [3:0]        cursor_start,
  input  logic [3:0]        cursor_end,
  input  logic              cursor_on,
`endif
  output logic [7:0]        char_line,
  output logic [7:0]        char_code,
  output logic [7:0]        char_attr,
  output logic [3:0]        char_pixel,
  output logic              cell_valid
);

  localparam int COL_W = $clog2(COLS + 1);
  localparam logic [COL_W-1:0] NCOLS    = COL_W'(COLS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  typedef enum logic [1:0] {IDLE, LEAD, ACTIVE} state_t;

  state_t           state;
  logic [COL_W-1:0] fetch_col;   // next column to fetch
  logic [COL_W-1:0] out_col;     // column currently on the outputs
  logic [3:0]       row;
  logic [7:0]       pf_code;
  logic [7:0]       pf_attr;
  logic [7:0]       pf_line;
  logic             fetch_pend;  // a VRAM word was captured and awaits its font row
  logic             more;
  logic             cursor_hit;
  logic [7:0]       font_row;

`ifdef MDA_CURSOR_EN
  logic [ADDR_W-1:0] pf_addr;    // VRAM address of the prefetched word
  assign cursor_hit = cursor_on && (pf_addr == cursor_addr) &&
                      (cursor_start <= row) && (row <= cursor_end);
`else
  assign cursor_hit = 1'b0;
`endif

  assign more     = (fetch_col < NCOLS);
  assign font_row = cursor_hit ? 8'hFF : font_data;

  // char_pixel doubles as the cell phase counter; vram_addr is the fetch address itself.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      state      <= IDLE;
      char_pixel <= 4'hF;
      char_line  <= 8'h00;
      char_code  <= 8'h00;
      char_attr  <= 8'h00;
      cell_valid <= 1'b0;
      vram_rd    <= 1'b0;
      vram_addr  <= '0;
      font_addr  <= 12'h000;
      fetch_col  <= '0;
      out_col    <= '0;
      row        <= 4'h0;
      pf_code    <= 8'h00;
      pf_attr    <= 8'h00;
      pf_line    <= 8'h00;
      fetch_pend <= 1'b0;
`ifdef MDA_CURSOR_EN
      pf_addr    <= '0;
`endif
    end else if (line_start) begin
      // Accepted in any state; an active line is simply abandoned.
      state      <= LEAD;
      char_pixel <= 4'd0;
      char_line  <= 8'h00;
      char_code  <= 8'h00;
      char_attr  <= 8'h00;
      cell_valid <= 1'b0;
      vram_rd    <= 1'b1;
      vram_addr  <= line_base;
      row        <= scanline;
      fetch_col  <= '0;
      out_col    <= '0;
      fetch_pend <= 1'b0;
    end else if (state != IDLE) begin
      vram_rd <= 1'b0;

      // Phase 1: VRAM word is on the bus. font_addr is loaded straight from it so the
      // ROM sees the address during phase 2 and returns the row during phase 3.
      if (char_pixel == 4'd1 && more) begin
        pf_code    <= vram_data[7:0];
        pf_attr    <= vram_data[15:8];
        font_addr  <= {vram_data[7:0], row};
        vram_addr  <= vram_addr + 1'b1;
        fetch_col  <= fetch_col + 1'b1;
        fetch_pend <= 1'b1;
`ifdef MDA_CURSOR_EN
        pf_addr    <= vram_addr;
`endif
      end

      if (char_pixel == 4'd3 && fetch_pend) begin
        pf_line    <= font_row;
        fetch_pend <= 1'b0;
      end

      if (char_pixel == 4'd8) begin
        if (state == ACTIVE && out_col == LAST_COL) begin
          // 4'hF (never 8) parks the serializer at a blank dot between lines.
          state      <= IDLE;
          char_pixel <= 4'hF;
          char_line  <= 8'h00;
          char_code  <= 8'h00;
          char_attr  <= 8'h00;
          cell_valid <= 1'b0;
        end else begin
          char_pixel <= 4'd0;
          vram_rd    <= more;
          char_line  <= pf_line;
          char_code  <= pf_code;
          char_attr  <= pf_attr;
          cell_valid <= 1'b1;
          if (state == LEAD) begin
            state   <= ACTIVE;
            out_col <= '0;
          end else begin
            out_col <= out_col + 1'b1;
          end
        end
      end else begin
        char_pixel <= char_pixel + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mda_char_fetch.sv
// Bench for mda_char_fetch (COLS=4): directed lines with a VRAM/ROM model; expected
// strobes, font addresses and cells are queued at stimulus time and popped by a
// negedge monitor whenever the DUT presents them.
module tb_mda_char_fetch;

  logic        pixclk = 1'b0;
  logic        rst = 1'b1;
  logic        line_start = 1'b0;
  logic [10:0] line_base = 11'h000;
  logic [3:0]  scanline = 4'h0;
  logic        vram_rd;
  logic [10:0] vram_addr;
  logic [15:0] vram_data = 16'h0000;
  logic [11:0] font_addr;
  logic [7:0]  font_data = 8'h00;
  logic [7:0]  char_line, char_code, char_attr;
  logic [3:0]  char_pixel;
  logic        cell_valid;
`ifdef MDA_CURSOR_EN
  logic [10:0] cursor_addr = 11'h000;
  logic [3:0]  cursor_start = 4'h0;
  logic [3:0]  cursor_end = 4'h0;
  logic        cursor_on = 1'b0;
`endif

  mda_char_fetch #(.COLS(4), .ADDR_W(11)) dut (
    .pixclk(pixclk), .rst(rst), .line_start(line_start), .line_base(line_base),
    .scanline(scanline), .vram_rd(vram_rd), .vram_addr(vram_addr), .vram_data(vram_data),
    .font_addr(font_addr), .font_data(font_data),
`ifdef MDA_CURSOR_EN
    .cursor_addr(cursor_addr), .cursor_start(cursor_start), .cursor_end(cursor_end),
    .cursor_on(cursor_on),
`endif
    .char_line(char_line), .char_code(char_code), .char_attr(char_attr),
    .char_pixel(char_pixel), .cell_valid(cell_valid)
  );

  always #5 pixclk = ~pixclk;

  int cyc = 0;
  always @(posedge pixclk) cyc = cyc + 1;

  function automatic logic [7:0] m_code(input logic [10:0] a);
    return 8'h41 + a[7:0];
  endfunction
  function automatic logic [7:0] m_attr(input logic [10:0] a);
    return 8'h06 + {5'b0, a[10:8]};
  endfunction

  // Synchronous VRAM and character ROM models.
  always @(posedge pixclk) begin
    vram_data <= vram_rd ? {m_attr(vram_addr), m_code(vram_addr)} : 16'hDEAD;
    font_data <= 8'hA0 + font_addr[11:4];
  end

  typedef struct { int cyc; logic [15:0] val; } ev_t;
  typedef struct { int cyc; logic [7:0] code; logic [7:0] attr; logic [7:0] line; } cell_t;
  ev_t   vq[$];
  ev_t   fq[$];
  cell_t cq[$];

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected events for a line whose line_start is high during cycle t.
  task automatic push_line(input int t, input logic [10:0] base, input logic [3:0] scan,
                           input int nstrobe, input int ncell);
    logic [10:0] a;
    ev_t   e;
    cell_t c;
    for (int j = 0; j < nstrobe; j++) begin
      a = base + 11'(j);
      e.cyc = t + 1 + 9 * j; e.val = {5'b0, a};
      vq.push_back(e);
      e.cyc = t + 3 + 9 * j; e.val = {4'h0, m_code(a), scan};
      fq.push_back(e);
    end
    for (int k = 0; k < ncell; k++) begin
      a = base + 11'(k);
      c.cyc = t + 10 + 9 * k; c.code = m_code(a); c.attr = m_attr(a);
      c.line = 8'hA0 + m_code(a);
`ifdef MDA_CURSOR_EN
      if (cursor_on && a == cursor_addr && cursor_start <= scan && scan <= cursor_end)
        c.line = 8'hFF;
`endif
      cq.push_back(c);
    end
  endtask

  // Monitor: pops expectations as the DUT presents strobes, font addresses and cells.
  ev_t   me;
  cell_t mc;
  cell_t held;
  bit    held_v = 1'b0;
  always @(negedge pixclk) begin
    if (vram_rd === 1'b1) begin
      if (vq.size() == 0) check("vram_rd_unexpected", 32'(vram_rd), 32'd0);
      else begin
        me = vq.pop_front();
        check("vram_rd_cycle", cyc, me.cyc);
        check("vram_addr", 32'(vram_addr), 32'(me.val));
      end
    end
    if (fq.size() > 0 && fq[0].cyc <= cyc) begin
      me = fq.pop_front();
      check("font_cycle", cyc, me.cyc);
      check("font_addr", 32'(font_addr), 32'(me.val));
    end
    if (cell_valid === 1'b1 && char_pixel == 4'd0) begin
      if (cq.size() == 0) check("cell_unexpected", 32'(cell_valid), 32'd0);
      else begin
        mc = cq.pop_front();
        check("cell_cycle", cyc, mc.cyc);
        check("char_code", 32'(char_code), 32'(mc.code));
        check("char_attr", 32'(char_attr), 32'(mc.attr));
        check("char_line", 32'(char_line), 32'(mc.line));
        held = mc; held_v = 1'b1;
      end
    end else if (cell_valid === 1'b1 && char_pixel == 4'd8 && held_v) begin
      check("cell_hold", {8'h0, char_code, char_attr, char_line},
            {8'h0, held.code, held.attr, held.line});
      held_v = 1'b0;
    end
  end

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge pixclk);
  endtask

  task automatic pulse_line(input logic [10:0] base, input logic [3:0] scan);
    line_base = base; scanline = scan; line_start = 1'b1;
    @(negedge pixclk);
    line_start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pixel"}, 32'(char_pixel), 32'hF);
    check({tag, "_valid"}, 32'(cell_valid), 32'd0);
    check({tag, "_line"}, 32'(char_line), 32'd0);
    check({tag, "_code"}, 32'(char_code), 32'd0);
    check({tag, "_attr"}, 32'(char_attr), 32'd0);
    check({tag, "_rd"}, 32'(vram_rd), 32'd0);
  endtask

  task automatic run_line(input logic [10:0] base, input logic [3:0] scan, input string tag);
    int t;
    t = cyc;
    push_line(t, base, scan, 4, 4);
    pulse_line(base, scan);
    wait_until(t + 46);
    check_idle(tag);
    repeat (3) @(negedge pixclk);
  endtask

  initial begin
    int t;
    int t2;
    // Power-on reset.
    repeat (3) @(negedge pixclk);
    rst = 1'b0;
    check_idle("por");
    check("por_vram_addr", 32'(vram_addr), 32'd0);
    check("por_font_addr", 32'(font_addr), 32'd0);
    @(negedge pixclk);

    // Single line, base 0x100, scanline 5.
    run_line(11'h100, 4'd5, "line1");

    // VRAM address wraps 0x7FF -> 0x000.
    run_line(11'h7FF, 4'd0, "wrap");

    // Restart during column 1 phase 4.
    t = cyc;
    push_line(t, 11'h200, 4'd3, 3, 2);
    pulse_line(11'h200, 4'd3);
    wait_until(t + 23);
    check("restart_phase_before", 32'(char_pixel), 32'd4);
    t2 = cyc;
    push_line(t2, 11'h300, 4'd2, 4, 4);
    pulse_line(11'h300, 4'd2);
    check("restart_lead_pixel", 32'(char_pixel), 32'd0);
    check("restart_lead_valid", 32'(cell_valid), 32'd0);
    wait_until(t2 + 9);
    check("restart_gap_valid", 32'(cell_valid), 32'd0);
    wait_until(t2 + 46);
    check_idle("restart");
    repeat (3) @(negedge pixclk);

    // Back-to-back: line_start on the final phase 8.
    t = cyc;
    push_line(t, 11'h010, 4'd1, 4, 4);
    pulse_line(11'h010, 4'd1);
    wait_until(t + 45);
    check("b2b_final_phase", 32'(char_pixel), 32'd8);
    t2 = cyc;
    push_line(t2, 11'h020, 4'd9, 4, 4);
    pulse_line(11'h020, 4'd9);
    check("b2b_no_idle_pixel", 32'(char_pixel), 32'd0);
    check("b2b_lead_valid", 32'(cell_valid), 32'd0);
    wait_until(t2 + 46);
    check_idle("b2b");
    repeat (3) @(negedge pixclk);

    // Reset for 3 cycles mid-line aborts it; no strobes afterwards.
    t = cyc;
    push_line(t, 11'h040, 4'd4, 2, 1);
    pulse_line(11'h040, 4'd4);
    wait_until(t + 13);
    rst = 1'b1;
    wait_until(t + 16);
    rst = 1'b0;
    check_idle("midrst");
    check("midrst_vram_addr", 32'(vram_addr), 32'd0);
    check("midrst_font_addr", 32'(font_addr), 32'd0);
    wait_until(t + 40);
    check("midrst_still_idle", 32'(char_pixel), 32'hF);

`ifdef MDA_CURSOR_EN
    cursor_addr = 11'h101; cursor_start = 4'd4; cursor_end = 4'd6; cursor_on = 1'b1;
    run_line(11'h100, 4'd5, "cur_hit");
    run_line(11'h100, 4'd7, "cur_row_out");
    cursor_on = 1'b0;
    run_line(11'h100, 4'd5, "cur_off");
`endif

    repeat (5) @(negedge pixclk);
    check("vram_queue_left", 32'(vq.size()), 32'd0);
    check("font_queue_left", 32'(fq.size()), 32'd0);
    check("cell_queue_left", 32'(cq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
